blake2_m_select: RTL and testbench
==================================

BLAKE2_M_SELECT -- requirements
Module: blake2_m_select

Interface
REQ-001 The block SHALL have no parameters; round count is fixed at 12 (BLAKE2b).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  single-cycle strobe: latch block and restart the schedule at round 0, column step.
REQ-005 block  input  1024  message block; word i = block[1023-64*i -: 64], i = 0..15; byte order is resolved upstream.
REQ-006 next  input  1  single-cycle strobe: advance the schedule by one step.
REQ-007 ready  output  1  high while a loaded schedule is active and outputs are valid.
REQ-008 round  output  4  current round, 0..11.
REQ-009 diag  output  1  0 = column step, 1 = diagonal step.
REQ-010 last  output  1  high when round = 11 and diag = 1.
REQ-011 g0_m0, g0_m1, g1_m0, g1_m1, g2_m0, g2_m1, g3_m0, g3_m1  output  64 each  message word pair for G-function instance 0..3.

Function
REQ-012 An internal 5-bit step counter SHALL run 0..23, with round = step[4:1] and diag = step[0].
REQ-013 The block SHALL hold 16 x 64-bit message registers, written only on load.
REQ-014 Row s = sigma[round mod 10] of the standard BLAKE2 sigma table SHALL be used for each round; rounds 10 and 11 reuse rows 0 and 1.
REQ-015 On a column step, Gi SHALL receive mi_m0 = word[s[2i]] and mi_m1 = word[s[2i+1]].
REQ-016 On a diagonal step, Gi SHALL receive mi_m0 = word[s[8+2i]] and mi_m1 = word[s[9+2i]].
REQ-017 All g*_m* outputs SHALL be registered and valid one cycle after load or next (latency 1), then held until the next update.
REQ-018 On load, the block SHALL set step = 0 and ready = 1; outputs reflect round 0, column step of the new block on the next cycle.
REQ-019 On next with ready = 1 and step < 23, the block SHALL increment step.
REQ-020 On next with ready = 1 and step = 23, ready SHALL fall to 0; step, round and the g outputs hold their values.
REQ-021 next with ready = 0 SHALL be ignored.
REQ-022 When load and next are asserted in the same cycle, load SHALL win and next is dropped.
REQ-023 load while a schedule is active SHALL abort it and restart at step 0 with the new block.
REQ-024 States: IDLE (ready = 0) and ACTIVE (ready = 1); IDLE -> ACTIVE on load; ACTIVE -> IDLE on next at step 23; ACTIVE -> ACTIVE on load.

Reset
REQ-025 reset SHALL asynchronously clear the message registers, step, and all g outputs to 0, clear ready and last to 0, and enter IDLE.
REQ-026 Reset asserted mid-schedule SHALL discard the schedule; a new load is required before ready rises again.

Structure
REQ-027 The sigma table (10 x 16 x 4-bit) and the constants NUM_ROUNDS = 12 and NUM_STEPS = 24 SHALL live in the shared blake2 package/include used by all blake2 modules.
REQ-028 The sigma row lookup SHALL be a combinational sub-module, blake2_sigma (input round, output row of 16 indices).

Verification
REQ-029 Load block with word i = i, then wait one cycle -> ready = 1, round = 0, diag = 0, g0..g3 (m0,m1) = (0,1) (2,3) (4,5) (6,7).
REQ-030 Issue one next -> diag = 1, pairs = (8,9) (10,11) (12,13) (14,15); a second next -> round = 1, pairs = (14,10) (4,8) (9,15) (13,6).
REQ-031 Issue 20 nexts after load -> round = 10 with row-0 pairs identical to REQ-029; 3 more nexts -> last = 1; one more next -> ready = 0 and outputs hold.
REQ-032 Assert load and next in the same cycle at step 5 -> step = 0 and round-0 column outputs of the new block.
REQ-033 Assert reset at step 7 -> all outputs 0 and ready = 0 immediately; next without load stays ignored.

Source files
------------

// File: rtl/blake2_pkg.sv
// blake2_pkg: constants, state type and sigma permutation table shared by the blake2 modules.
package blake2_pkg;
    localparam int NUM_ROUNDS = 12;
    localparam int NUM_STEPS = 2 * NUM_ROUNDS;
    localparam logic [4:0] LAST_STEP = 5'(NUM_STEPS - 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    // One row per entry, index 0 in the top nibble.
    localparam logic [63:0] SIGMA [10] = '{
        64'h0123456789abcdef,
        64'hea489fd61c02b753,
        64'hb8c052fdae367194,
        64'h7931dcbe265a40f8,
        64'h905724afe1bc683d,
        64'h2c6a0b834d75fe19,
        64'hc51fed4a0763928b,
        64'hdb7ec13950f4862a,
        64'h6fe9b308c2d714a5,
        64'ha2847615fb9e3cd0
    };
endpackage

// File: rtl/blake2_sigma.sv
// blake2_sigma: combinational sigma row lookup; rounds 10 and 11 wrap to rows 0 and 1.
module blake2_sigma
    import blake2_pkg::*;
(
    input  logic [3:0]       round_i,
    output logic [15:0][3:0] row_o
);
    logic [3:0]  r;
    logic [63:0] s;

    assign r = (round_i >= 4'd10) ? round_i - 4'd10 : round_i;
    assign s = SIGMA[r];

    always_comb begin
        for (int i = 0; i < 16; i++) row_o[i] = s[63-4*i -: 4];
    end
endmodule

// File: rtl/blake2_m_select.sv
// blake2_m_select: holds a 1024-bit message block and steps through the BLAKE2b
// column/diagonal schedule, presenting the registered word pair for each G instance.
module blake2_m_select
    import blake2_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [1023:0] block,
    input  logic          next,
    output logic          ready,
    output logic [3:0]    round,
    output logic          diag,
    output logic          last,
    output logic [63:0]   g0_m0,
    output logic [63:0]   g0_m1,
    output logic [63:0]   g1_m0,
    output logic [63:0]   g1_m1,
    output logic [63:0]   g2_m0,
    output logic [63:0]   g2_m1,
    output logic [63:0]   g3_m0,
    output logic [63:0]   g3_m1
);
    state_e           state_q, state_d;
    logic [4:0]       step_q, step_d;
    logic [63:0]      msg_q [16];
    logic [63:0]      msg_d [16];
    logic [63:0]      g_q [8];
    logic [63:0]      g_d [8];
    logic [15:0][3:0] row;
    logic             active, adv, upd;

    assign active = (state_q == ACTIVE);
    assign adv    = next && active && (step_q != LAST_STEP);
    assign upd    = load || adv;

    always_comb begin
        state_d = load ? ACTIVE : (next && active && step_q == LAST_STEP) ? IDLE : state_q;
        step_d  = load ? 5'd0 : adv ? step_q + 5'd1 : step_q;
    end

    // The pair for the step being entered is selected from the block being latched.
    always_comb begin
        for (int i = 0; i < 16; i++) msg_d[i] = load ? block[1023-64*i -: 64] : msg_q[i];
    end

    blake2_sigma u_sigma (
        .round_i(step_d[4:1]),
        .row_o  (row)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            g_d[2*i]   = msg_d[row[{step_d[0], 2'(i), 1'b0}]];
            g_d[2*i+1] = msg_d[row[{step_d[0], 2'(i), 1'b1}]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            for (int i = 0; i < 16; i++) msg_q[i] <= '0;
            for (int i = 0; i < 8; i++) g_q[i] <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            msg_q   <= msg_d;
            if (upd) g_q <= g_d;
        end
    end

    assign ready = active;
    assign round = step_q[4:1];
    assign diag  = step_q[0];
    assign last  = (step_q == LAST_STEP);
    assign g0_m0 = g_q[0];
    assign g0_m1 = g_q[1];
    assign g1_m0 = g_q[2];
    assign g1_m1 = g_q[3];
    assign g2_m0 = g_q[4];
    assign g2_m1 = g_q[5];
    assign g3_m0 = g_q[6];
    assign g3_m1 = g_q[7];
endmodule

// File: tb/tb_blake2_m_select.sv
// tb_blake2_m_select: table vectors, directed corner sequences and random stimulus
// checked against a step/round arithmetic model of the message schedule.
module tb_blake2_m_select;
    logic          clk = 0, reset = 1, load = 0, next = 0;
    logic [1023:0] block = '0;
    logic          ready, diag, last;
    logic [3:0]    round;
    logic [63:0]   g0_m0, g0_m1, g1_m0, g1_m1, g2_m0, g2_m1, g3_m0, g3_m1;
    logic [63:0]   dg [8];

    int errs = 0, checks = 0;

    int SIG [10][16] = '{
        '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
        '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
        '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
        '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
        '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
        '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
        '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
        '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
        '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
        '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}
    };

    // Reference model
    bit          m_ready = 0;
    int          m_step = 0;
    logic [63:0] m_w [16];
    logic [63:0] m_g [8];

    typedef struct {
        bit ld;
        bit nx;
        bit rdy;
        int rnd;
        bit dg;
        int p [8];
    } vec_t;
    vec_t tbl [3];

    blake2_m_select dut (
        .clk(clk), .reset(reset), .load(load), .block(block), .next(next),
        .ready(ready), .round(round), .diag(diag), .last(last),
        .g0_m0(g0_m0), .g0_m1(g0_m1), .g1_m0(g1_m0), .g1_m1(g1_m1),
        .g2_m0(g2_m0), .g2_m1(g2_m1), .g3_m0(g3_m0), .g3_m1(g3_m1)
    );

    assign dg[0] = g0_m0;
    assign dg[1] = g0_m1;
    assign dg[2] = g1_m0;
    assign dg[3] = g1_m1;
    assign dg[4] = g2_m0;
    assign dg[5] = g2_m1;
    assign dg[6] = g3_m0;
    assign dg[7] = g3_m1;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function void model_reset();
        m_ready = 0;
        m_step = 0;
        for (int i = 0; i < 16; i++) m_w[i] = '0;
        for (int i = 0; i < 8; i++) m_g[i] = '0;
    endfunction

    function void model_pairs();
        int r, d;
        r = (m_step / 2) % 10;
        d = m_step % 2;
        for (int i = 0; i < 4; i++) begin
            m_g[2*i]   = m_w[SIG[r][d*8 + 2*i]];
            m_g[2*i+1] = m_w[SIG[r][d*8 + 2*i + 1]];
        end
    endfunction

    function void model_clock(input bit ld, input bit nx, input logic [1023:0] blk);
        if (ld) begin
            for (int i = 0; i < 16; i++) m_w[i] = blk[1023-64*i -: 64];
            m_step = 0;
            m_ready = 1;
            model_pairs();
        end else if (nx && m_ready) begin
            if (m_step == 23) m_ready = 0;
            else begin
                m_step++;
                model_pairs();
            end
        end
    endfunction

    task automatic chk(input string nm);
        logic [6:0]   ea, aa;
        logic [511:0] eg, ag;
        ea = {m_ready, 4'(m_step / 2), 1'(m_step % 2), (m_step / 2 == 11) && (m_step % 2 == 1)};
        aa = {ready, round, diag, last};
        for (int i = 0; i < 8; i++) begin
            eg[511-64*i -: 64] = m_g[i];
            ag[511-64*i -: 64] = dg[i];
        end
        checks++;
        if (aa !== ea) begin
            errs++;
            $display("FAIL %s ctrl{ready,round,diag,last}: got %b want %b", nm, aa, ea);
        end
        checks++;
        if (ag !== eg) begin
            errs++;
            $display("FAIL %s pairs: got %h want %h", nm, ag, eg);
        end
    endtask

    task automatic tick(input bit ld, input bit nx, input logic [1023:0] blk);
        load = ld;
        next = nx;
        block = blk;
        @(posedge clk);
        model_clock(ld, nx, blk);
        #1;
        load = 0;
        next = 0;
        @(negedge clk);
    endtask

    task automatic chk_const(input string nm, input bit rdy, input int rnd, input bit d, input bit lst);
        checks++;
        if ({ready, round, diag, last} !== {rdy, 4'(rnd), d, lst}) begin
            errs++;
            $display("FAIL %s: got ready=%0b round=%0d diag=%0b last=%0b want ready=%0b round=%0d diag=%0b last=%0b",
                     nm, ready, round, diag, last, rdy, rnd, d, lst);
        end
    endtask

    task automatic chk_row0(input string nm);
        bit ok;
        ok = 1;
        for (int i = 0; i < 8; i++) if (dg[i] !== 64'(i)) ok = 0;
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s row0 pairs: got %0d,%0d %0d,%0d %0d,%0d %0d,%0d want 0..7", nm,
                     dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], dg[7]);
        end
    endtask

    function automatic logic [1023:0] rand_block();
        logic [1023:0] b;
        for (int i = 0; i < 32; i++) b[1023-32*i -: 32] = $urandom;
        return b;
    endfunction

    initial begin
        logic [1023:0] blk_i, blk_n;
        logic [63:0]   held [8];
        bit            ok;
        for (int i = 0; i < 16; i++) blk_i[1023-64*i -: 64] = 64'(i);

        tbl[0] = '{ld: 1, nx: 0, rdy: 1, rnd: 0, dg: 0, p: '{ 0, 1, 2, 3, 4, 5, 6, 7}};
        tbl[1] = '{ld: 0, nx: 1, rdy: 1, rnd: 0, dg: 1, p: '{ 8, 9,10,11,12,13,14,15}};
        tbl[2] = '{ld: 0, nx: 1, rdy: 1, rnd: 1, dg: 0, p: '{14,10, 4, 8, 9,15,13, 6}};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_held");
        reset = 0;
        @(negedge clk);
        chk("after_reset");
        tick(0, 1, blk_i);
        chk("next_while_idle");

        for (int k = 0; k < 3; k++) begin
            tick(tbl[k].ld, tbl[k].nx, blk_i);
            chk($sformatf("vec%0d_model", k));
            chk_const($sformatf("vec%0d_ctrl", k), tbl[k].rdy, tbl[k].rnd, tbl[k].dg, 0);
            ok = 1;
            for (int i = 0; i < 8; i++) if (dg[i] !== 64'(tbl[k].p[i])) ok = 0;
            checks++;
            if (!ok) begin
                errs++;
                $display("FAIL vec%0d_pairs: got %0d,%0d %0d,%0d %0d,%0d %0d,%0d", k,
                         dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], dg[7]);
            end
        end

        // Run to the wrap rows, the final step and past it.
        repeat (18) tick(0, 1, blk_i);
        chk("round10");
        chk_const("round10_ctrl", 1, 10, 0, 0);
        chk_row0("round10");
        repeat (3) tick(0, 1, blk_i);
        chk("last_step");
        chk_const("last_step_ctrl", 1, 11, 1, 1);
        for (int i = 0; i < 8; i++) held[i] = dg[i];
        tick(0, 1, blk_i);
        chk("past_last");
        checks++;
        if (ready !== 1'b0 || round !== 4'd11) begin
            errs++;
            $display("FAIL past_last_ready: got ready=%0b round=%0d want ready=0 round=11", ready, round);
        end
        ok = 1;
        for (int i = 0; i < 8; i++) if (dg[i] !== held[i]) ok = 0;
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL past_last_hold: g0_m0 got %h want %h", dg[0], held[0]);
        end
        tick(0, 1, blk_i);
        chk("idle_next_ignored");

        // Load and next together mid-schedule: load wins with the new block.
        tick(1, 0, blk_i);
        repeat (5) tick(0, 1, blk_i);
        chk("step5");
        blk_n = rand_block();
        tick(1, 1, blk_n);
        chk("load_next_same_cycle");
        checks++;
        if (g0_m0 !== blk_n[1023 -: 64] || g3_m1 !== blk_n[1023-64*7 -: 64]) begin
            errs++;
            $display("FAIL load_wins_pairs: got %h %h want %h %h", g0_m0, g3_m1,
                     blk_n[1023 -: 64], blk_n[1023-64*7 -: 64]);
        end

        // Asynchronous reset mid-schedule.
        repeat (7) tick(0, 1, blk_n);
        chk("step7");
        #2 reset = 1;
        #1;
        model_reset();
        chk("async_reset");
        @(negedge clk);
        reset = 0;
        tick(0, 1, blk_n);
        chk("next_after_reset");
        chk_const("next_after_reset_ctrl", 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(39) == 0, $urandom_range(3) != 0, rand_block());
            chk($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
